// File: rtl/y_run_monitor.sv
// rtl/y_run_monitor.sv - rising-edge, run-length and threshold monitor for a 1-bit stream
module y_run_monitor #(
  parameter int CNT_W = 8,
  parameter int RUN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             y_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             rise_out,
  output logic [CNT_W-1:0] pulse_cnt_out,
  output logic [RUN_W-1:0] run_len_out,
  output logic [RUN_W-1:0] max_run_out,
  output logic             hit_out
);

  typedef enum logic {S_LOW = 1'b0, S_HIGH = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};

  state_t           state_q, state_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] max_q, max_d, max_base;
  logic             hit_q, hit_d, hit_base;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_LOW;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
      run_q   <= '0;
      max_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      max_q   <= max_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    // Clear zeroes the statistics first; this cycle's event then lands on the zeroed values.
    cnt_base = clr_i ? '0 : cnt_q;
    max_base = clr_i ? '0 : max_q;
    hit_base = clr_i ? 1'b0 : hit_q;

    state_d = state_q;
    rise_d  = 1'b0;
    cnt_d   = cnt_base;
    run_d   = run_q;
    max_d   = max_base;
    hit_d   = hit_base;

    case (state_q)
      S_LOW: begin
        if (y_i) begin
          state_d = S_HIGH;
          rise_d  = 1'b1;
          cnt_d   = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
          run_d   = RUN_W'(1);
        end else begin
          run_d = '0;
        end
      end
      S_HIGH: begin
        if (y_i) begin
          run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
        end else begin
          state_d = S_LOW;
          max_d   = (run_q > max_base) ? run_q : max_base;
          run_d   = '0;
        end
      end
      default: state_d = S_LOW;
    endcase

    // Only a rise updates the count, so only a rise can reach the threshold.
    if (rise_d && (thresh_i != '0) && (cnt_d == thresh_i)) begin
      hit_d = 1'b1;
    end
  end

  assign rise_out      = rise_q;
  assign pulse_cnt_out = cnt_q;
  assign run_len_out   = run_q;
  assign max_run_out   = max_q;
  assign hit_out       = hit_q;

endmodule

// File: tb/tb_y_run_monitor.sv
// tb/tb_y_run_monitor.sv - directed and random checks of y_run_monitor against a stream model
module tb_y_run_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       y   = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] thresh8 = '0;
  logic [2:0] thresh3 = '0;

  logic       rise8, hit8, rise3, hit3;
  logic [7:0] cnt8;
  logic [2:0] cnt3;
  logic [3:0] run8, max8, run3, max3;

  int errors = 0;
  int checks = 0;

  // stream model: unbounded raw counts, clamped only when compared
  int m_prev, m_run, m_cnt, m_max, m_rise, m_hit8, m_hit3;

  always #5 clk = ~clk;

  y_run_monitor #(.CNT_W(8), .RUN_W(4)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .y_i(y), .clr_i(clr), .thresh_i(thresh8),
    .rise_out(rise8), .pulse_cnt_out(cnt8), .run_len_out(run8),
    .max_run_out(max8), .hit_out(hit8)
  );

  y_run_monitor #(.CNT_W(3), .RUN_W(4)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .y_i(y), .clr_i(clr), .thresh_i(thresh3),
    .rise_out(rise3), .pulse_cnt_out(cnt3), .run_len_out(run3),
    .max_run_out(max3), .hit_out(hit3)
  );

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst) begin
      m_prev = 0; m_run = 0; m_cnt = 0; m_max = 0; m_rise = 0; m_hit8 = 0; m_hit3 = 0;
    end else begin
      if (clr) begin
        m_cnt = 0; m_max = 0; m_hit8 = 0; m_hit3 = 0;
      end
      m_rise = (y && !m_prev) ? 1 : 0;
      if (m_rise == 1) begin
        m_cnt++;
        m_run = 1;
        if (thresh8 != 0 && min_i(m_cnt, 255) == int'(thresh8)) m_hit8 = 1;
        if (thresh3 != 0 && min_i(m_cnt, 7) == int'(thresh3)) m_hit3 = 1;
      end else if (y) begin
        m_run++;
      end else begin
        if (m_prev == 1) begin
          if (min_i(m_run, 15) > m_max) m_max = min_i(m_run, 15);
        end
        m_run = 0;
      end
      m_prev = y ? 1 : 0;
    end
  endtask

  task automatic cycle(input logic yv, input logic cv);
    y   = yv;
    clr = cv;
    @(posedge clk);
    model_step();
    #1;
    chk("rise8", int'(rise8), m_rise);
    chk("cnt8",  int'(cnt8),  min_i(m_cnt, 255));
    chk("run8",  int'(run8),  min_i(m_run, 15));
    chk("max8",  int'(max8),  m_max);
    chk("hit8",  int'(hit8),  m_hit8);
    chk("rise3", int'(rise3), m_rise);
    chk("cnt3",  int'(cnt3),  min_i(m_cnt, 7));
    chk("hit3",  int'(hit3),  m_hit3);
    clr = 1'b0;
  endtask

  int rise_count;

  initial begin
    m_prev = 0; m_run = 0; m_cnt = 0; m_max = 0; m_rise = 0; m_hit8 = 0; m_hit3 = 0;

    // reset held with y high, then released with y high
    rst = 1'b0;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    chk("rst_zero_cnt", int'(cnt8), 0);
    rst = 1'b1;
    cycle(1'b1, 1'b0);
    chk("post_rst_rise", int'(rise8), 1);
    chk("post_rst_cnt", int'(cnt8), 1);
    chk("post_rst_run", int'(run8), 1);

    // basic pattern
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
    chk("basic_run3", int'(run8), 3);
    cycle(1'b0, 1'b0); cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
    chk("basic_cnt", int'(cnt8), 2);
    chk("basic_max", int'(max8), 3);

    // run saturation
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
    chk("sat_run", int'(run8), 15);
    cycle(1'b0, 1'b0);
    chk("sat_max", int'(max8), 15);
    chk("sat_run_zero", int'(run8), 0);

    // threshold
    thresh8 = 8'd3;
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0);
      chk("thr_hit", int'(hit8), (i >= 2) ? 1 : 0);
      cycle(1'b0, 1'b0);
    end
    thresh8 = 8'd9;
    cycle(1'b0, 1'b0);
    chk("thr_sticky", int'(hit8), 1);
    cycle(1'b0, 1'b1);
    chk("thr_clr_hit", int'(hit8), 0);
    chk("thr_clr_cnt", int'(cnt8), 0);
    thresh8 = 8'd0;

    // count saturation on the 3-bit instance
    rise_count = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 1'b0);
      rise_count += int'(rise3);
      cycle(1'b0, 1'b0);
    end
    chk("cnt3_sat", int'(cnt3), 7);
    chk("rise3_pulses", rise_count, 9);

    // clear on a rising sample, then clear mid-run
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); end
    cycle(1'b1, 1'b1);
    chk("clr_rise_cnt", int'(cnt8), 1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    chk("clr_mid_cnt", int'(cnt8), 0);
    chk("clr_mid_rise", int'(rise8), 0);
    chk("clr_mid_run", int'(run8), 3);
    cycle(1'b1, 1'b0);
    chk("clr_mid_run4", int'(run8), 4);
    cycle(1'b0, 1'b1);
    chk("clr_end_max", int'(max8), 4);

    // reset mid-run discards the run
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
    rst = 1'b0;
    cycle(1'b1, 1'b0);
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    chk("rst_mid_max", int'(max8), 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) thresh8 = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) thresh3 = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 79) != 0);
      cycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
    end
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/y_run_monitor.md
# y_run_monitor

Downstream monitor for the 1-bit output stream of the `scirc528_bh` sequential circuit. Each clock it samples that stream and does four things: detects rising edges, counts them in a saturating counter, tracks the length of the current high run and keeps the longest completed run. It also raises a sticky flag when the edge count reaches a programmable threshold. It is a two-state FSM plus registered datapath, and its outputs feed the exercise bench and waveform checks.

## Interface
- `CNT_W`, 8, width of the rising-edge counter and of the threshold.
- `RUN_W`, 4, width of the run-length registers.
- `clk_i`  in  1  single clock; all logic updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-low; has priority over every other input.
- `y_i`  in  1  serial stream from `scirc528_bh.y_out`, sampled on each rising edge.
- `clr_i`  in  1  synchronous clear of the statistics; active-high.
- `thresh_i`  in  CNT_W  edge-count threshold; 0 disables `hit_out`.
- `rise_out`  out  1  one-cycle pulse; registered edge-detect of `y_i`.
- `pulse_cnt_out`  out  CNT_W  number of rising edges seen; saturates at 2^CNT_W-1.
- `run_len_out`  out  RUN_W  length of the current high run; saturates at 2^RUN_W-1.
- `max_run_out`  out  RUN_W  longest completed high run.
- `hit_out`  out  1  sticky flag; set when the count equals `thresh_i`.

## Operation
- FSM states:
  - S_LOW: the last sample was 0, or the block is just out of reset.
  - S_HIGH: inside a high run.
- S_LOW, `y_i`=1:
  - go to S_HIGH
  - `rise_out`<=1
  - `pulse_cnt_out`<=cnt+1 (saturating)
  - `run_len_out`<=1
- S_LOW, `y_i`=0:
  - stay in S_LOW
  - `rise_out`<=0
  - `run_len_out` stays 0
- S_HIGH, `y_i`=1:
  - stay in S_HIGH
  - `rise_out`<=0
  - `run_len_out`<=run+1 (saturating; holds at 2^RUN_W-1)
- S_HIGH, `y_i`=0:
  - go to S_LOW
  - `max_run_out`<=max(max_run, run_len)
  - `run_len_out`<=0
- Counters never wrap. At saturation the value holds and further events are ignored by that counter.
- `hit_out`:
  - set on the edge where the updated count equals `thresh_i` and `thresh_i`≠0
  - stays set until `clr_i` or reset
  - later changes to `thresh_i` do not clear it.
- `clr_i`=1:
  - `pulse_cnt_out`, `max_run_out` and `hit_out` are zeroed first; the same-cycle event is then applied to the zeroed values.
  - FSM state and `run_len_out` are not cleared, so a run in progress is not recounted as a new rise.
- Simultaneous events:
  - clr + rise: `pulse_cnt_out`=1, and `hit_out`=1 only if `thresh_i`=1.
  - clr + run end: `max_run_out`=ending `run_len_out`.
  - rise + saturation: `rise_out` still pulses.
- Reset:
  - `rst_i`=0 forces S_LOW and all outputs to 0, regardless of `y_i`/`clr_i`.
  - Applied mid-run, it discards that run; the run is not folded into `max_run_out`.
  - After release, if `y_i`=1 at the first edge with `rst_i`=1, that edge counts as a rise.

## Timing
- All outputs are registered. A `y_i` sample at edge k is reflected in the outputs just after edge k (1-cycle latency from input setup).
- `rise_out` is high for exactly one cycle per 0→1 transition of the sampled stream, including the post-reset case.
- `hit_out` asserts on the same edge as the `pulse_cnt_out` update that reaches the threshold.
- `y_i`, `clr_i` and `thresh_i` must be stable around the rising edge. No combinational input→output paths.
- Reset values: `rise_out`=0, `pulse_cnt_out`=0, `run_len_out`=0, `max_run_out`=0, `hit_out`=0, state=S_LOW.

## Test plan
- Reset:
  - Stimulus: `rst_i`=0 for 2 edges with `y_i`=1; release with `y_i`=1.
  - Required: all outputs 0 during reset. First edge after release gives `rise_out`=1, `pulse_cnt_out`=1, `run_len_out`=1.
- Basic pattern:
  - Stimulus: `y_i` sequence 1,1,1,0,1,0.
  - Required: `rise_out` pulses at samples 1 and 5. `run_len_out` goes 1,2,3,0,1,0. Final `pulse_cnt_out`=2, `max_run_out`=3.
- Run saturation:
  - Stimulus: `y_i`=1 for 20 edges, then 0.
  - Required: `run_len_out` holds at 15 from edge 15 on. After the fall, `max_run_out`=15 and `run_len_out`=0.
- Threshold:
  - Stimulus: `thresh_i`=3; four isolated 1-cycle pulses.
  - Required: `hit_out` rises on the edge where `pulse_cnt_out` becomes 3 and stays 1 at count 4. `clr_i` then zeroes `hit_out` and `pulse_cnt_out`.
- Count saturation:
  - Stimulus: `CNT_W`=3; 9 isolated pulses.
  - Required: `pulse_cnt_out` reaches 7 and holds, while `rise_out` still pulses 9 times.
- Clear interactions:
  - Stimulus: with `pulse_cnt_out`=5, assert `clr_i` on a rising sample. Separately, assert `clr_i` mid-run.
  - Required: rising-sample case gives `pulse_cnt_out`=1. Mid-run case gives `pulse_cnt_out`=0, no new `rise_out`, and `run_len_out` continues incrementing.
